// File: rtl/clkadc_pulse_monitor.sv
// Pulse-period monitor for the ADC debug tick: measures edge-to-edge
// intervals, declares lock after a run of in-tolerance periods, and flags
// out-of-tolerance periods and missing pulses.
module clkadc_pulse_monitor #(
    parameter int unsigned BPS_PARA = 50,
    parameter int unsigned TOL      = 1,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        mon_en,
    input  logic        pulse_in,
    input  logic        err_clr,
    output logic [12:0] period,
    output logic        period_valid,
    output logic        locked,
    output logic        err_pulse,
    output logic        err_timeout,
    output logic [7:0]  err_cnt
);

    localparam int unsigned CNT_W   = 13;
    localparam int unsigned MEAS_W  = CNT_W + 1;
    localparam int unsigned MATCH_W = 4;
    localparam int unsigned ERR_W   = 8;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(2 * BPS_PARA - 1);

    // Tolerance window; the lower bound never drops below one cycle.
    localparam int unsigned MATCH_LO = (BPS_PARA > TOL) ? (BPS_PARA - TOL) : 1;
    localparam int unsigned MATCH_HI = BPS_PARA + TOL;

    localparam logic [MATCH_W:0] LOCK_TARGET = (MATCH_W + 1)'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_e;

    state_e               state_q,        state_d;
    logic [CNT_W-1:0]     cnt_q,          cnt_d;
    logic [MATCH_W-1:0]   match_cnt_q,    match_cnt_d;
    logic                 pulse_prev_q;
    logic [CNT_W-1:0]     period_q,       period_d;
    logic                 period_valid_q, period_valid_d;
    logic                 locked_q,       locked_d;
    logic                 err_pulse_q,    err_pulse_d;
    logic                 err_timeout_q,  err_timeout_d;
    logic [ERR_W-1:0]     err_cnt_q,      err_cnt_d;

    logic                 rise_c;
    logic [MEAS_W-1:0]    meas_c;
    logic                 match_c;
    logic                 timeout_c;
    logic [CNT_W-1:0]     cnt_inc_c;
    logic [MATCH_W:0]     match_next_c;

    // Edge detect, measured interval and tolerance / timeout qualifiers.
    always_comb begin
        rise_c       = pulse_in & ~pulse_prev_q;
        meas_c       = MEAS_W'(cnt_q) + MEAS_W'(1);
        match_c      = (32'(meas_c) >= MATCH_LO) && (32'(meas_c) <= MATCH_HI);
        timeout_c    = (cnt_q == TIMEOUT_CNT) && !rise_c;
        cnt_inc_c    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        match_next_c = (MATCH_W + 1)'(match_cnt_q) + (MATCH_W + 1)'(1);
    end

    // Next-state and registered-output logic for the lock FSM.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        match_cnt_d    = match_cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_pulse_d    = 1'b0;
        err_timeout_d  = 1'b0;
        locked_d       = 1'b0;
        err_cnt_d      = err_cnt_q;

        if (!mon_en) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            match_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ACQ;
                    cnt_d   = '0;
                end
                S_ACQ: begin
                    if (rise_c) begin
                        state_d     = S_TRACK;
                        cnt_d       = '0;
                        match_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                S_TRACK, S_LOCKED: begin
                    if (rise_c) begin
                        cnt_d          = '0;
                        period_d       = CNT_W'(meas_c);
                        period_valid_d = 1'b1;
                        if (state_q == S_TRACK) begin
                            if (match_c) begin
                                if (match_next_c == LOCK_TARGET) begin
                                    state_d     = S_LOCKED;
                                    match_cnt_d = '0;
                                end else begin
                                    match_cnt_d = MATCH_W'(match_next_c);
                                end
                            end else begin
                                match_cnt_d = '0;
                            end
                        end else if (!match_c) begin
                            state_d     = S_TRACK;
                            match_cnt_d = '0;
                            err_pulse_d = 1'b1;
                        end
                    end else if (timeout_c) begin
                        state_d       = S_ACQ;
                        cnt_d         = cnt_inc_c;
                        match_cnt_d   = '0;
                        err_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    match_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == S_LOCKED);

        // Clear request beats a coincident error increment.
        if (err_clr) begin
            err_cnt_d = '0;
        end else if ((err_pulse_d || err_timeout_d) && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            match_cnt_q    <= '0;
            pulse_prev_q   <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            match_cnt_q    <= match_cnt_d;
            pulse_prev_q   <= pulse_in;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_pulse_q    <= err_pulse_d;
            err_timeout_q  <= err_timeout_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err_pulse    = err_pulse_q;
    assign err_timeout  = err_timeout_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_clkadc_pulse_monitor.sv
// Bench for clkadc_pulse_monitor: directed lock/error/timeout scenarios plus
// a randomized phase, all checked against a timestamp-based reference model.
module tb_clkadc_pulse_monitor;

    localparam int BPS  = 50;
    localparam int TOLV = 1;
    localparam int LCK  = 4;

    localparam int M_IDLE   = 0;
    localparam int M_ACQ    = 1;
    localparam int M_TRACK  = 2;
    localparam int M_LOCKED = 3;

    logic        clk = 1'b0;
    logic        RST;
    logic        mon_en;
    logic        pulse_in;
    logic        err_clr;
    logic [12:0] period;
    logic        period_valid;
    logic        locked;
    logic        err_pulse;
    logic        err_timeout;
    logic [7:0]  err_cnt;

    clkadc_pulse_monitor #(
        .BPS_PARA (BPS),
        .TOL      (TOLV),
        .LOCK_CNT (LCK)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .mon_en       (mon_en),
        .pulse_in     (pulse_in),
        .err_clr      (err_clr),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_timeout  (err_timeout),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time-stamped view of the monitor.
    int t       = 0;
    int m_mode  = M_IDLE;
    bit m_prev  = 1'b0;
    int m_tlast = 0;
    int m_run   = 0;
    int m_period = 0;
    bit m_pv    = 1'b0;
    bit m_ep    = 1'b0;
    bit m_et    = 1'b0;
    int m_err   = 0;

    int          ep_seen = 0;
    int          et_seen = 0;
    logic [12:0] rise_period;
    logic        rise_pv;
    logic        rise_ep;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit p, input bit c);
        bit rise;
        int lo;
        int hi;
        int d;
        bit ok;
        t++;
        lo = (BPS - TOLV < 1) ? 1 : BPS - TOLV;
        hi = BPS + TOLV;
        m_pv = 1'b0;
        m_ep = 1'b0;
        m_et = 1'b0;
        if (r) begin
            m_mode   = M_IDLE;
            m_prev   = 1'b0;
            m_run    = 0;
            m_period = 0;
            m_err    = 0;
            return;
        end
        rise   = p && !m_prev;
        m_prev = p;
        if (!en) begin
            m_mode = M_IDLE;
            m_run  = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ACQ;
        end else if (m_mode == M_ACQ) begin
            if (rise) begin
                m_mode  = M_TRACK;
                m_tlast = t;
                m_run   = 0;
            end
        end else begin
            d = t - m_tlast;
            if (rise) begin
                m_period = d;
                m_pv     = 1'b1;
                m_tlast  = t;
                ok       = (d >= lo) && (d <= hi);
                if (m_mode == M_TRACK) begin
                    m_run = ok ? m_run + 1 : 0;
                    if (m_run == LCK) begin
                        m_mode = M_LOCKED;
                        m_run  = 0;
                    end
                end else if (!ok) begin
                    m_ep   = 1'b1;
                    m_mode = M_TRACK;
                    m_run  = 0;
                end
            end else if (d == 2 * BPS) begin
                m_et   = 1'b1;
                m_mode = M_ACQ;
                m_run  = 0;
            end
        end
        if (c) m_err = 0;
        else if ((m_ep || m_et) && m_err < 255) m_err++;
    endtask

    task automatic cycle(input bit r, input bit en, input bit p, input bit c);
        RST      = r;
        mon_en   = en;
        pulse_in = p;
        err_clr  = c;
        @(posedge clk);
        model_step(r, en, p, c);
        #1;
        check("outputs",
              32'({period, period_valid, locked, err_pulse, err_timeout, err_cnt}),
              32'({13'(m_period), m_pv, m_mode == M_LOCKED, m_ep, m_et, 8'(m_err)}));
        if (err_pulse)   ep_seen++;
        if (err_timeout) et_seen++;
    endtask

    // One pulse of n cycles (one high cycle then n-1 low); records the rise-cycle outputs.
    task automatic pulse(input int n, input bit en);
        cycle(1'b0, en, 1'b1, 1'b0);
        rise_period = period;
        rise_pv     = period_valid;
        rise_ep     = err_pulse;
        repeat (n - 1) cycle(1'b0, en, 1'b0, 1'b0);
    endtask

    task automatic lock_from_acq();
        repeat (5) pulse(BPS, 1'b1);
    endtask

    initial begin
        int n;
        bit en;
        bit clr;
        bit rs;
        bit hold;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_outputs",
              32'({period, period_valid, locked, err_pulse, err_timeout, err_cnt}), 32'd0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Steady 50-cycle stream: lock after four matched periods.
        pulse(BPS, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            pulse(BPS, 1'b1);
            check("lock_period", 32'(rise_period), 32'd50);
            check("lock_pv", 32'(rise_pv), 32'd1);
            if (i == 4) check("prelock_locked", 32'(locked), 32'd0);
        end
        check("locked_after_4", 32'(locked), 32'd1);
        check("lock_err_cnt", 32'(err_cnt), 32'd0);

        // One 53-cycle interval while locked, then relock.
        ep_seen = 0;
        pulse(53, 1'b1);
        pulse(BPS, 1'b1);
        check("p53_period", 32'(rise_period), 32'd53);
        check("p53_err_pulse", 32'(rise_ep), 32'd1);
        check("p53_locked", 32'(locked), 32'd0);
        check("p53_err_cnt", 32'(err_cnt), 32'd1);
        repeat (4) pulse(BPS, 1'b1);
        check("relock", 32'(locked), 32'd1);
        check("p53_ep_count", 32'(ep_seen), 32'd1);

        // Tolerance edges: 49/51 match, 52/48 do not.
        pulse(49, 1'b1);
        pulse(51, 1'b1);
        pulse(52, 1'b1);
        check("tol_49_51_locked", 32'(locked), 32'd1);
        pulse(BPS, 1'b1);
        check("tol_52_period", 32'(rise_period), 32'd52);
        check("tol_52_err", 32'(rise_ep), 32'd1);
        check("tol_52_err_cnt", 32'(err_cnt), 32'd2);
        pulse(BPS, 1'b1);
        pulse(48, 1'b1);
        pulse(BPS, 1'b1);
        check("tol_48_period", 32'(rise_period), 32'd48);
        repeat (3) pulse(BPS, 1'b1);
        check("tol_48_reset_run", 32'(locked), 32'd0);
        check("tol_track_err_cnt", 32'(err_cnt), 32'd2);
        pulse(BPS, 1'b1);
        check("tol_relock", 32'(locked), 32'd1);

        // Held-high input: single timeout.
        et_seen = 0;
        repeat (150) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("hold_timeouts", 32'(et_seen), 32'd1);
        check("hold_locked", 32'(locked), 32'd0);
        check("hold_err_cnt", 32'(err_cnt), 32'd3);

        // Saturate err_cnt with repeated timeouts.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (300) pulse(2 * BPS + 1, 1'b1);
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        // Clear request coincident with a timeout.
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2 * BPS - 1) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("clr_vs_to_strobe", 32'(err_timeout), 32'd1);
        check("clr_vs_to_cnt", 32'(err_cnt), 32'd0);

        // Reset mid-interval while locked.
        lock_from_acq();
        pulse(53, 1'b1);
        pulse(BPS, 1'b1);
        repeat (4) pulse(BPS, 1'b1);
        check("prerst_locked", 32'(locked), 32'd1);
        repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("midrst_outputs",
              32'({period, period_valid, locked, err_pulse, err_timeout, err_cnt}), 32'd0);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Drop mon_en while locked with a non-zero error count.
        lock_from_acq();
        pulse(53, 1'b1);
        pulse(BPS, 1'b1);
        repeat (4) pulse(BPS, 1'b1);
        repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) pulse(BPS, 1'b0);
        check("dis_locked", 32'(locked), 32'd0);
        check("dis_period", 32'(period), 32'd50);
        check("dis_err_cnt", 32'(err_cnt), 32'd1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized intervals, enables, clears and resets.
        repeat (80) begin
            n    = int'($urandom_range(46, 110));
            if (n > 56 && $urandom_range(0, 2) != 0) n = int'($urandom_range(48, 52));
            en   = ($urandom_range(0, 24) != 0);
            clr  = ($urandom_range(0, 19) == 0);
            rs   = ($urandom_range(0, 59) == 0);
            hold = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < n; i++) begin
                cycle(rs && (i == 3), en, (i == 0) || (hold && i < 6), clr && (i == 7));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clkadc_pulse_monitor.md
CLKADC_PULSE_MONITOR -- requirements
Module: clkadc_pulse_monitor

Interface
REQ-001 Parameter BPS_PARA, default 50: expected pulse period in clk cycles, legal range 2..4095.
REQ-002 Parameter TOL, default 1: allowed period deviation in cycles, ± around BPS_PARA.
REQ-003 Parameter LOCK_CNT, default 4: consecutive in-tolerance periods required to declare lock, legal range 1..15.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 mon_en  in  1  monitor enable; low forces IDLE.
REQ-007 pulse_in  in  1  monitored pulse stream (ADC debug tick), synchronous to clk.
REQ-008 err_clr  in  1  one-cycle request to clear err_cnt.
REQ-009 period  out  13  last measured edge-to-edge period in cycles.
REQ-010 period_valid  out  1  one-cycle strobe: period updated.
REQ-011 locked  out  1  high while in LOCKED state.
REQ-012 err_pulse  out  1  one-cycle strobe: out-of-tolerance period seen while LOCKED.
REQ-013 err_timeout  out  1  one-cycle strobe: no rising edge within timeout window.
REQ-014 err_cnt  out  8  saturating count of err_pulse plus err_timeout events.

Function
REQ-015 Rising edge detection SHALL use a registered copy of pulse_in: rise = pulse_in & ~pulse_prev. A level held high counts as one edge only.
REQ-016 Interval counter cnt (13 bit) SHALL clear to 0 on the cycle rise is detected and increment by 1 on every other cycle in ACQ, TRACK or LOCKED, saturating at 8191.
REQ-017 Measured period SHALL be cnt+1 at the rise cycle. A pulse every N cycles therefore measures N.
REQ-018 States: IDLE, ACQ, TRACK, LOCKED. The FSM SHALL leave IDLE for ACQ on the cycle after mon_en is sampled high.
REQ-019 ACQ: the first rise SHALL move the FSM to TRACK and clear cnt. No period_valid is produced.
REQ-020 TRACK/LOCKED: each rise SHALL load period and assert period_valid on the next cycle (latency 1).
REQ-021 A period is a match iff BPS_PARA-TOL <= period <= BPS_PARA+TOL. Comparison is unsigned; the lower bound clamps at 1.
REQ-022 TRACK: on a match, match_cnt increments; when match_cnt reaches LOCK_CNT, the FSM SHALL enter LOCKED and clear match_cnt. On a mismatch, match_cnt clears and the FSM stays in TRACK.
REQ-023 LOCKED: on a mismatch, the FSM SHALL assert err_pulse for 1 cycle (same cycle as period_valid), drop locked, and return to TRACK with match_cnt=0.
REQ-024 Timeout: in TRACK or LOCKED, if cnt reaches 2*BPS_PARA-1 with no rise, the FSM SHALL assert err_timeout for 1 cycle, drop locked and return to ACQ. A rise in that same cycle takes priority and no timeout occurs.
REQ-025 err_cnt SHALL increment by 1 per err_pulse or err_timeout cycle and saturate at 255.
REQ-026 err_clr SHALL clear err_cnt on the next cycle; it wins over a simultaneous increment.
REQ-027 mon_en low in any state SHALL move the FSM to IDLE next cycle and clear cnt, match_cnt and locked. It SHALL suppress period_valid, err_pulse and err_timeout, and SHALL retain period and err_cnt.
REQ-028 locked SHALL be registered and asserted from the first cycle in LOCKED.

Reset
REQ-029 While RST is high at a clk edge, the block SHALL set the FSM to IDLE and clear cnt, match_cnt, pulse_prev, period, period_valid, locked, err_pulse, err_timeout and err_cnt to 0.
REQ-030 Reset asserted mid-measurement SHALL abort with no strobe emitted. After RST falls, operation resumes in IDLE/ACQ per mon_en.

Verification
REQ-031 With BPS_PARA=50, TOL=1, LOCK_CNT=4, mon_en=1 and a 1-cycle pulse every 50 cycles, the bench SHALL check:
- every pulse after the first gives period=50 with period_valid one cycle after the rise;
- locked rises in the cycle after the 4th matched period;
- err_cnt stays 0.
REQ-032 With the bench locked, one interval of 53 cycles SHALL produce period=53, err_pulse=1 for 1 cycle, locked=0, err_cnt=1. Four further 50-cycle periods SHALL relock.
REQ-033 With the bench locked, holding pulse_in high SHALL give no further rises. err_timeout SHALL fire when cnt=99, with locked=0, state ACQ and err_cnt incremented.
REQ-034 Periods of 49 and 51 SHALL count as matches; 48 and 52 SHALL be mismatches that reset match_cnt in TRACK.
REQ-035 Forcing 300 timeouts SHALL give err_cnt=255 (saturated). err_clr coincident with an error event SHALL give err_cnt=0.
REQ-036 Asserting RST mid-interval while locked SHALL clear all outputs the next cycle with no strobes. Dropping mon_en SHALL keep period and err_cnt and clear locked.
